// File: rtl/alarm_stim_seq.sv
// Stimulus sequencer for the car-alarm benches. Drives N_SIG alarm inputs
// through a timed pattern sequence (binary, walking one or Gray), holding each
// pattern for STEP_CYCLES clocks. It also counts the steps that saw any
// passive-alarm response. All outputs are registered.
module alarm_stim_seq #(
    parameter int N_SIG       = 3,
    parameter int N_STEPS     = 6,
    parameter int STEP_CYCLES = 1,
    parameter int N_PASS      = 2,
    localparam int CW         = $clog2(N_STEPS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              hold,
    input  logic [N_PASS-1:0] passive_in,
    output logic [N_SIG-1:0]  sig,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     step_idx,
    output logic [CW-1:0]     active_cnt
);

    // The dwell counter needs at least one bit, even when each step lasts a single cycle.
    localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_STEP  = CW'(N_STEPS - 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [N_SIG-1:0]   cnt_q;       // running binary count used for count/Gray patterns
    logic [N_SIG-1:0]   sig_q;
    logic               busy_q;
    logic               done_q;
    logic [CW-1:0]      step_q;
    logic [DW-1:0]      dwell_q;
    logic [CW-1:0]      active_q;

    logic [N_SIG-1:0]   cnt_d;
    logic [N_SIG-1:0]   pattern_d;
    logic [N_SIG-1:0]   seed_d;

    // Next pattern for the latched mode, derived from the current count or pattern.
    always_comb begin
        cnt_d     = cnt_q + N_SIG'(1);
        pattern_d = cnt_d;
        unique case (mode_q)
            2'd1:    pattern_d = {sig_q[N_SIG-2:0], sig_q[N_SIG-1]};
            2'd2:    pattern_d = cnt_d ^ (cnt_d >> 1);
            default: pattern_d = cnt_d;
        endcase
        // The first pattern of a run depends on the mode presented with start.
        seed_d = (mode == 2'd1) ? N_SIG'(1) : '0;
    end

    // Sequencer FSM: IDLE -> RUN -> DONE -> IDLE, with every output registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'd0;
            cnt_q    <= '0;
            sig_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            step_q   <= '0;
            dwell_q  <= '0;
            active_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    sig_q <= '0;
                    if (start) begin
                        mode_q   <= mode;
                        cnt_q    <= '0;
                        sig_q    <= seed_d;
                        step_q   <= '0;
                        dwell_q  <= '0;
                        active_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // While hold is high everything, including the response count, is frozen.
                    if (!hold) begin
                        if (dwell_q != LAST_DWELL) begin
                            dwell_q <= dwell_q + DW'(1);
                        end else begin
                            dwell_q <= '0;
                            if (|passive_in) begin
                                active_q <= active_q + CW'(1);
                            end
                            if (step_q == LAST_STEP) begin
                                sig_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                step_q <= step_q + CW'(1);
                                sig_q  <= pattern_d;
                                cnt_q  <= cnt_d;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // A single cycle here so done is exactly one clock wide; start is ignored.
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sig        = sig_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign step_idx   = step_q;
    assign active_cnt = active_q;

endmodule

// File: tb/tb_alarm_stim_seq.sv
// Directed bench for alarm_stim_seq. Three instances cover the default
// configuration, a five-step walking-one run and a two-cycle-per-step Gray run.
module tb_alarm_stim_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic [1:0] mode;
    logic [1:0] passive_in;
    logic       start0, start1, start2;

    logic [2:0] sig0, sig1, sig2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [2:0] step0, step1, step2;
    logic [2:0] act0, act1, act2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alarm_stim_seq #(.N_SIG(3), .N_STEPS(6), .STEP_CYCLES(1), .N_PASS(2)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode), .hold(hold),
        .passive_in(passive_in), .sig(sig0), .busy(busy0), .done(done0),
        .step_idx(step0), .active_cnt(act0)
    );

    alarm_stim_seq #(.N_SIG(3), .N_STEPS(5), .STEP_CYCLES(1), .N_PASS(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode), .hold(hold),
        .passive_in(passive_in), .sig(sig1), .busy(busy1), .done(done1),
        .step_idx(step1), .active_cnt(act1)
    );

    alarm_stim_seq #(.N_SIG(3), .N_STEPS(6), .STEP_CYCLES(2), .N_PASS(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode), .hold(hold),
        .passive_in(passive_in), .sig(sig2), .busy(busy2), .done(done2),
        .step_idx(step2), .active_cnt(act2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Binary-mode run on the default instance. Optional hold at one step
    // (with passive_in high, which must be ignored), per-step passive mask,
    // and an optional start re-pulse plus mode change mid-run.
    task automatic run0(input string name, input int hold_step, input int hold_len,
                        input logic [5:0] pmask, input int repulse_step,
                        input logic [2:0] exp_active);
        @(negedge clk);
        mode   = 2'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check({name, ":active_clr"}, act0, 0);
        for (int s = 0; s < 6; s++) begin
            check({name, ":sig"},  sig0, s);
            check({name, ":step"}, step0, s);
            check({name, ":busy"}, busy0, 1);
            check({name, ":done_low"}, done0, 0);
            if (s == hold_step) begin
                hold       = 1'b1;
                passive_in = 2'b11;
                for (int h = 0; h < hold_len; h++) begin
                    @(negedge clk);
                    check({name, ":hold_sig"},  sig0, s);
                    check({name, ":hold_step"}, step0, s);
                end
                hold = 1'b0;
            end
            passive_in = pmask[s] ? 2'b01 : 2'b00;
            if (s == repulse_step) begin
                start0 = 1'b1;
                mode   = 2'd1;
            end
            @(negedge clk);
            start0     = 1'b0;
            passive_in = 2'b00;
        end
        check({name, ":end_sig"},    sig0, 0);
        check({name, ":end_done"},   done0, 1);
        check({name, ":end_busy"},   busy0, 0);
        check({name, ":end_active"}, act0, exp_active);
        @(negedge clk);
        check({name, ":done_once"},  done0, 0);
        check({name, ":idle_sig"},   sig0, 0);
        check({name, ":keep_active"}, act0, exp_active);
        $display("run %s: done, active_cnt=%0d (expected %0d)", name, act0, exp_active);
    endtask

    initial begin
        logic [2:0] exp1 [5];
        logic [2:0] exp2 [6];
        exp1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        exp2 = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111};

        reset = 1'b1; hold = 1'b0; mode = 2'd0; passive_in = 2'b00;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst:sig",    sig0, 0);
        check("rst:busy",   busy0, 0);
        check("rst:done",   done0, 0);
        check("rst:step",   step0, 0);
        check("rst:active", act0, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle:sig", sig0, 0);
        $display("reset: state checked");

        // Plain binary run.
        run0("binary", -1, 0, 6'b000000, -1, 3'd0);

        // Hold for three cycles while sig=2.
        run0("hold", 2, 3, 6'b000000, -1, 3'd0);

        // Passive response on steps 1 and 4; start re-pulse and mode change mid-run.
        run0("passive", -1, 0, 6'b010010, 2, 3'd2);
        repeat (3) @(negedge clk);
        check("idle:keep_active", act0, 2);

        // Walking one, five steps.
        @(negedge clk);
        mode = 2'd1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; mode = 2'd0;
        for (int s = 0; s < 5; s++) begin
            check("walk:sig",  sig1, exp1[s]);
            check("walk:step", step1, s);
            @(negedge clk);
        end
        check("walk:end_sig",  sig1, 0);
        check("walk:end_done", done1, 1);
        $display("run walk: finished at sig=%0b", sig1);

        // Gray, two cycles per step.
        @(negedge clk);
        mode = 2'd2; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; mode = 2'd0;
        for (int c = 0; c < 12; c++) begin
            check("gray:sig",  sig2, exp2[c / 2]);
            check("gray:busy", busy2, 1);
            @(negedge clk);
        end
        check("gray:end_sig",  sig2, 0);
        check("gray:end_done", done2, 1);
        @(negedge clk);
        check("gray:done_once", done2, 0);
        $display("run gray: finished at sig=%0b", sig2);

        // Reset while step_idx=3, with responses counted on steps 0..2.
        @(negedge clk);
        mode = 2'd0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            passive_in = 2'b10;
            @(negedge clk);
        end
        passive_in = 2'b00;
        check("abort:pre_step",   step0, 3);
        check("abort:pre_active", act0, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort:sig",    sig0, 0);
        check("abort:busy",   busy0, 0);
        check("abort:step",   step0, 0);
        check("abort:active", act0, 0);
        check("abort:done",   done0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort:no_done", done0, 0);
            check("abort:idle_sig", sig0, 0);
        end
        $display("reset mid-run: aborted");

        run0("after_abort", -1, 0, 6'b100000, -1, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
